// File: rtl/ifu_pkg.sv
// ifu_pkg: shared encodings and defaults for the instruction fetch unit
package ifu_pkg;
    localparam logic [1:0] PCSEL_NONE   = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_JR     = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;
endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction memory read port and decode handshake of the fetch unit
interface ifu_if #(parameter int XLEN = 32, parameter int IM_ADDR_W = 10);
    logic                 imem_req;
    logic [IM_ADDR_W-1:0] imem_addr;
    logic                 imem_rvalid;
    logic [XLEN-1:0]      imem_rdata;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [XLEN-1:0]      instr;
    logic [XLEN-1:0]      instr_pc;
    modport master (output imem_req, imem_addr, instr_valid, instr, instr_pc,
                    input imem_rvalid, imem_rdata, instr_ready);
    modport slave  (input imem_req, imem_addr, instr_valid, instr, instr_pc,
                    output imem_rvalid, imem_rdata, instr_ready);
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: power-of-two synchronous FIFO; flush wins over push
module ifu_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push && !flush) mem[wr] <= din;
    assign head = mem[rd];
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC owner, single-outstanding imem reader and prefetch queue
// feeding decode; redirects flush the queue and squash the in-flight read.
module ifu_prefetch import ifu_pkg::*; #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int FQ_DEPTH = 4,
    parameter int IM_ADDR_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      pc_select,
    input  logic            if_branch,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] rdata,
    ifu_if.master           bus
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    state_t            state;
    logic [XLEN-1:0]   fetch_pc, target;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              redirect, credit, issue, push, pop;
    always_comb begin
        redirect = pc_select != PCSEL_NONE && (pc_select != PCSEL_BRANCH || if_branch);
        target = (pc_select == PCSEL_JR ? rdata : pc_select == PCSEL_JUMP ? jpc : bpc) & ~XLEN'(3);
        // an outstanding read has already reserved one queue slot
        credit = count < (state == RUN ? CW'(FQ_DEPTH) : CW'(FQ_DEPTH - 1));
        issue = reset && !redirect && credit && (state == RUN || (state == WAIT && bus.imem_rvalid));
        push = state == WAIT && bus.imem_rvalid && !redirect;
        pop = bus.instr_valid && bus.instr_ready;
    end
    assign bus.imem_req = issue;
    assign bus.imem_addr = fetch_pc[IM_ADDR_W+1:2];
    assign bus.instr_valid = count != '0;
    assign {bus.instr_pc, bus.instr} = bus.instr_valid ? head : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= redirect ? target : issue ? fetch_pc + XLEN'(4) : fetch_pc;
            if (redirect) state <= (state != RUN && !bus.imem_rvalid) ? DROP : RUN;
            else if (state == RUN) state <= issue ? WAIT : RUN;
            else if (bus.imem_rvalid) state <= issue ? WAIT : RUN;
        end
    end
    // fetch_pc moves only on issue or redirect, so while WAITing it is request PC + 4
    ifu_fifo #(.W(2 * XLEN), .DEPTH(FQ_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(redirect),
        .din({fetch_pc - XLEN'(4), bus.imem_rdata}),
        .count(count),
        .head(head)
    );
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenarios plus a randomized run against a stream-level model
module tb_ifu_prefetch;
    import ifu_pkg::*;
    logic clk = 0;
    logic reset = 0;
    logic [1:0] pc_select;
    logic if_branch;
    logic [31:0] bpc, jpc, rdata;
    int vec = 0, err = 0, lat_cfg = 1, pend = 0, overlap = 0;
    logic inject = 0;
    logic [11:0] paddr;

    ifu_if #(.XLEN(32), .IM_ADDR_W(12)) bus();
    ifu_prefetch #(.XLEN(32), .RESET_PC(32'h0000_3000), .FQ_DEPTH(4), .IM_ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .pc_select(pc_select), .if_branch(if_branch),
        .bpc(bpc), .jpc(jpc), .rdata(rdata), .bus(bus));

    always #5 clk = ~clk;

    // memory returns word address * 4, i.e. the low 14 PC bits
    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {18'b0, pc[13:2], 2'b00};
    endfunction

    initial begin
        bus.imem_rvalid = 0;
        bus.imem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                pend = 0;
                bus.imem_rvalid = inject;
                bus.imem_rdata = 32'hDEAD_BEEF;
            end else if (pend == 1) begin
                pend = 0;
                bus.imem_rvalid = 1;
                bus.imem_rdata = {18'b0, paddr, 2'b00};
            end else begin
                if (pend > 1) pend--;
                bus.imem_rvalid = 0;
            end
            @(negedge clk);
            if (reset && bus.imem_req) begin
                if (pend != 0) overlap++;
                pend = lat_cfg != 0 ? lat_cfg : int'($urandom_range(1, 3));
                paddr = bus.imem_addr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); endtask
    task automatic idle(); pc_select = PCSEL_NONE; if_branch = 0; bpc = 0; jpc = 0; rdata = 0; endtask
    task automatic redir(input logic [1:0] s, input logic br, input logic [31:0] b, input logic [31:0] j, input logic [31:0] r);
        pc_select = s; if_branch = br; bpc = b; jpc = j; rdata = r;
    endtask
    task automatic do_reset(input int lat, input logic rdy);
        cyc(); reset = 0; idle(); lat_cfg = lat; bus.instr_ready = rdy;
        repeat (2) cyc();
        #1 reset = 1;
    endtask
    task automatic wait_valid(output logic ok);
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(); mid();
            if (bus.instr_valid) begin ok = 1; return; end
        end
    endtask

    task automatic test_reset();
        cyc(); reset = 0; idle(); lat_cfg = 1; bus.instr_ready = 0;
        repeat (2) cyc();
        mid();
        vec++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 12'hC00)
            begin err++; $display("FAIL reset_imem: req=%b addr=%h want req=0 addr=c00", bus.imem_req, bus.imem_addr); end
        vec++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0)
            begin err++; $display("FAIL reset_queue: valid=%b instr=%h pc=%h want 0/0/0", bus.instr_valid, bus.instr, bus.instr_pc); end
        cyc(); #1 reset = 1;
        mid();
        vec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'hC00)
            begin err++; $display("FAIL first_req: req=%b addr=%h want 1/c00", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1, 1);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) cyc();
            mid();
            vec++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'hC00 + 12'(k))
                begin err++; $display("FAIL stream_req[%0d]: req=%b addr=%h want 1/%h", k, bus.imem_req, bus.imem_addr, 12'hC00 + 12'(k)); end
            if (k >= 2) begin
                e = 32'h3000 + 32'(4 * (k - 2));
                vec++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr !== word_of(e))
                    begin err++; $display("FAIL stream_out[%0d]: valid=%b pc=%h instr=%h want pc=%h instr=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, e, word_of(e)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        logic [31:0] e;
        do_reset(1, 0);
        for (int k = 0; k < 10; k++) begin
            if (k != 0) cyc();
            mid();
            if (bus.imem_req === 1'b1) nreq++;
        end
        cyc(); bus.instr_ready = 1;
        mid();
        vec++;
        if (nreq != 4 || bus.imem_req !== 1'b0)
            begin err++; $display("FAIL bp_fill: reqs=%0d req_now=%b want 4/0", nreq, bus.imem_req); end
        for (int j = 0; j < 5; j++) begin
            if (j != 0) begin cyc(); mid(); end
            e = 32'h3000 + 32'(4 * j);
            vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr !== word_of(e))
                begin err++; $display("FAIL bp_drain[%0d]: valid=%b pc=%h instr=%h want pc=%h", j, bus.instr_valid, bus.instr_pc, bus.instr, e); end
            if (j == 1) begin
                vec++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'hC04)
                    begin err++; $display("FAIL bp_resume: req=%b addr=%h want 1/c04", bus.imem_req, bus.imem_addr); end
            end
        end
    endtask

    task automatic test_branch_inflight();
        logic ok;
        do_reset(3, 1);
        mid();
        cyc(); redir(PCSEL_BRANCH, 1, 32'h3101, 32'h0, 32'h0);
        mid();
        vec++;
        if (bus.imem_req !== 1'b0) begin err++; $display("FAIL br_redirect_req: req=%b want 0", bus.imem_req); end
        cyc(); idle();
        mid();
        vec++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
            begin err++; $display("FAIL br_drop1: req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid); end
        cyc(); mid();
        vec++;
        if (bus.imem_req !== 1'b0) begin err++; $display("FAIL br_drop2: req=%b want 0", bus.imem_req); end
        cyc(); mid();
        vec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'hC40)
            begin err++; $display("FAIL br_target_req: req=%b addr=%h want 1/c40", bus.imem_req, bus.imem_addr); end
        wait_valid(ok);
        vec++;
        if (!ok || bus.instr_pc !== 32'h3100 || bus.instr !== word_of(32'h3100))
            begin err++; $display("FAIL br_first: found=%b pc=%h instr=%h want pc=3100 instr=%h", ok, bus.instr_pc, bus.instr, word_of(32'h3100)); end
    endtask

    task automatic test_notaken_priority();
        logic ok;
        logic [31:0] e;
        do_reset(1, 1);
        for (int k = 0; k < 10; k++) begin
            if (k != 0) cyc();
            if (k == 3) redir(PCSEL_BRANCH, 0, 32'h7000, 32'h7100, 32'h7200);
            if (k == 4) idle();
            mid();
            if (k >= 2) begin
                e = 32'h3000 + 32'(4 * (k - 2));
                vec++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e)
                    begin err++; $display("FAIL nt_seq[%0d]: valid=%b pc=%h want %h", k, bus.instr_valid, bus.instr_pc, e); end
            end
        end
        cyc(); redir(PCSEL_JR, 1, 32'h5000, 32'h6000, 32'h4002);
        mid();
        cyc(); idle();
        mid();
        vec++;
        if (bus.instr_valid !== 1'b0) begin err++; $display("FAIL jr_bubble: valid=%b want 0", bus.instr_valid); end
        wait_valid(ok);
        vec++;
        if (!ok || bus.instr_pc !== 32'h4000 || bus.instr !== word_of(32'h4000))
            begin err++; $display("FAIL jr_first: found=%b pc=%h instr=%h want pc=4000", ok, bus.instr_pc, bus.instr); end
    endtask

    task automatic test_simultaneous();
        logic ok;
        do_reset(1, 1);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            mid();
        end
        cyc(); redir(PCSEL_JUMP, 0, 32'h0, 32'h5000, 32'h0);
        mid();
        vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h3008 || bus.imem_req !== 1'b0)
            begin err++; $display("FAIL sim_pop: valid=%b pc=%h req=%b want 1/3008/0", bus.instr_valid, bus.instr_pc, bus.imem_req); end
        cyc(); idle();
        mid();
        vec++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h400)
            begin err++; $display("FAIL sim_after: valid=%b req=%b addr=%h want 0/1/400", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        wait_valid(ok);
        vec++;
        if (!ok || bus.instr_pc !== 32'h5000)
            begin err++; $display("FAIL sim_first: found=%b pc=%h want 5000", ok, bus.instr_pc); end
    endtask

    task automatic test_wrap();
        logic ok;
        do_reset(1, 1);
        mid();
        cyc(); redir(PCSEL_JUMP, 0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        mid();
        cyc(); idle();
        mid();
        wait_valid(ok);
        vec++;
        if (!ok || bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== 32'h3FFC)
            begin err++; $display("FAIL wrap_top: found=%b pc=%h instr=%h want fffffffc/3ffc", ok, bus.instr_pc, bus.instr); end
        cyc(); mid();
        vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'h0)
            begin err++; $display("FAIL wrap_zero: valid=%b pc=%h instr=%h want 1/0/0", bus.instr_valid, bus.instr_pc, bus.instr); end
    endtask

    task automatic test_reset_midread();
        logic ok;
        do_reset(3, 1);
        mid();
        cyc(); reset = 0;
        cyc(); cyc();
        #1 inject = 1;
        cyc();
        #1 reset = 1; inject = 0;
        mid();
        vec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'hC00)
            begin err++; $display("FAIL rst_mid_req: req=%b addr=%h want 1/c00", bus.imem_req, bus.imem_addr); end
        cyc(); mid();
        vec++;
        if (bus.instr_valid !== 1'b0) begin err++; $display("FAIL rst_mid_stale: valid=%b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); end
        wait_valid(ok);
        vec++;
        if (!ok || bus.instr_pc !== 32'h3000 || bus.instr !== word_of(32'h3000))
            begin err++; $display("FAIL rst_mid_first: found=%b pc=%h instr=%h want 3000/%h", ok, bus.instr_pc, bus.instr, word_of(32'h3000)); end
    endtask

    task automatic test_random();
        logic [31:0] e = 32'h3000, tgt, b, j, r;
        logic [1:0] s;
        logic br, rd, prev = 0;
        int pops = 0;
        do_reset(0, 1);
        for (int n = 0; n < 800; n++) begin
            if (n != 0) cyc();
            bus.instr_ready = $urandom_range(0, 9) < 7;
            s = $urandom_range(0, 99) < 8 ? 2'($urandom_range(1, 3)) : 2'b00;
            br = 1'($urandom);
            b = $urandom; j = $urandom; r = $urandom;
            redir(s, br, b, j, r);
            rd = s == 2'b11 || s == 2'b10 || (s == 2'b01 && br);
            tgt = (s == 2'b11 ? r : s == 2'b10 ? j : b) & 32'hFFFF_FFFC;
            mid();
            if (prev) begin
                vec++;
                if (bus.instr_valid !== 1'b0) begin err++; $display("FAIL rnd_bubble[%0d]: valid=%b want 0", n, bus.instr_valid); end
            end
            if (rd) begin
                vec++;
                if (bus.imem_req !== 1'b0) begin err++; $display("FAIL rnd_redirect_req[%0d]: req=%b want 0", n, bus.imem_req); end
            end
            if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
                vec++;
                pops++;
                if (bus.instr_pc !== e || bus.instr !== word_of(e))
                    begin err++; $display("FAIL rnd_pop[%0d]: pc=%h instr=%h want pc=%h instr=%h", n, bus.instr_pc, bus.instr, e, word_of(e)); end
                e = e + 32'h4;
            end
            if (rd) e = tgt;
            prev = rd;
        end
        cyc(); idle();
        vec++;
        if (overlap != 0) begin err++; $display("FAIL rnd_outstanding: overlapping requests=%0d want 0", overlap); end
        vec++;
        if (pops < 80) begin err++; $display("FAIL rnd_progress: pops=%0d want >=80", pops); end
    endtask

    initial begin
        idle();
        bus.instr_ready = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_inflight();
        test_notaken_priority();
        test_simultaneous();
        test_wrap();
        test_reset_midread();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with a decoupled prefetch queue. It owns the fetch PC, issues word reads to the instruction memory with a valid/response protocol, buffers returned instructions with their PCs in a FIFO of configurable depth, and hands them to decode over a valid/ready handshake. Branch, jump and jump-register redirects flush the queue and squash any in-flight read, so the rest of the pipeline can stall without freezing the PC.

## Interface
- XLEN, 32: instruction and PC width.
- RESET_PC, 32'h0000_3000: PC of the first fetch after reset.
- FQ_DEPTH, 4: prefetch queue entries (power of two, 2..16).
- IM_ADDR_W, 10: word-address width to instruction memory.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pc_select  input  2  redirect kind: 00 none, 01 branch, 10 jump (jpc), 11 jump-register (rdata).
- if_branch  input  1  branch taken; qualifies pc_select=01.
- bpc  input  XLEN  branch target.
- jpc  input  XLEN  jump target.
- rdata  input  XLEN  jump-register target.
- imem_req  output  1  read request, one cycle per request.
- imem_addr  output  IM_ADDR_W  word address, fetch_pc[IM_ADDR_W+1:2].
- imem_rvalid  input  1  read data valid, latency >= 1 cycle after imem_req.
- imem_rdata  input  XLEN  instruction word.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode accepts head.
- instr  output  XLEN  head instruction.
- instr_pc  output  XLEN  head PC.

## Operation
- Redirect is active when pc_select=10 or 11, or pc_select=01 with if_branch=1. pc_select=01 with if_branch=0 is no redirect.
- Redirect target low two bits are forced to 0. Priority: jump-register, then jump, then branch. Only one kind is selectable per cycle.
- At most one read is outstanding.
- Credit = FQ_DEPTH − count − outstanding. A request is issued only when credit > 0 and the state permits.
- States:
  - RUN: no read outstanding. Issue if credit > 0, then go to WAIT.
  - WAIT: read outstanding. When imem_rvalid arrives, push {fetch_pc_of_req, imem_rdata}. In the same cycle, issue the next request if credit > 0 (stay in WAIT); otherwise go to RUN.
  - DROP: a squashed read is outstanding. When imem_rvalid arrives, discard the data and go to RUN.
- On issue, fetch_pc advances by 4, modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal.
- Redirect in any state:
  - Queue count is set to 0 and fetch_pc is set to the target at that edge.
  - No request is issued in the redirect cycle.
  - If a read is outstanding and imem_rvalid is not asserted that cycle, go to DROP; otherwise go to RUN. A response coinciding with a redirect is discarded.
- A pop (instr_valid & instr_ready) in the redirect cycle completes normally before the flush takes effect.
- A push and a pop in the same cycle leave count unchanged. The credit rule guarantees that a push never finds the queue full.
- Reset mid-operation clears everything immediately. A late imem_rvalid for a pre-reset request must be ignored: the state after reset is RUN with no outstanding read.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC[IM_ADDR_W+1:2], instr_valid=0, instr=0, instr_pc=0, fetch_pc=RESET_PC, state RUN, count=0.
- First imem_req is asserted in the first cycle after reset deasserts.
- imem_req and imem_addr are combinational from state and registers. They must not depend combinationally on instr_ready.
- Response to queue: the pushed entry is visible on instr_valid, instr and instr_pc in the cycle after imem_rvalid. This is one-cycle bubble latency.
- With 1-cycle memory and instr_ready held high, sustained throughput is 1 instruction per cycle after a 2-cycle startup.
- Redirect to first new instruction:
  - Redirect at edge N.
  - imem_req for the target in cycle N+1 (or when DROP exits).
  - instr_valid in cycle N+3 for 1-cycle memory.
- instr_valid is 0 in the cycle after a redirect.

## Structure
- Shared package ifu_pkg:
  - pc_select encodings (PCSEL_NONE, PCSEL_BRANCH, PCSEL_JUMP, PCSEL_JR).
  - state enum (RUN, WAIT, DROP).
  - Default RESET_PC constant.
- One sub-module, ifu_fifo: parametrised synchronous FIFO (width 2*XLEN, FQ_DEPTH).
  - Ports: push, pop, flush, count, head data.
  - Flush has priority over push.
- Next-PC selection, credit logic and the FSM live in ifu_prefetch.

## Test plan
- Reset and stream: 1-cycle memory returning addr*4, instr_ready=1 → imem_addr 0xC00, 0xC01, …; instr_pc 0x3000, 0x3004, … on consecutive cycles from cycle 2.
- Backpressure: instr_ready=0 for 10 cycles with FQ_DEPTH=4 → exactly 4 entries queued, then imem_req=0. Release → entries 0x3000..0x300C pop in order, fetch resumes at 0x3010.
- Branch with in-flight read: 3-cycle memory, pc_select=01, if_branch=1, bpc=0x3101 while a read is outstanding → DROP. The stale rdata is never presented; next instr_pc=0x3100.
- Not-taken and priority: pc_select=01, if_branch=0 → no flush, sequence continues. pc_select=11, rdata=0x4000 while bpc=0x5000 → next instr_pc=0x4000.
- Simultaneous events: a redirect coinciding with imem_rvalid and a pop → the popped entry is delivered, the response is discarded, count=0 next cycle, and the next request goes to the target.
- Wrap and reset mid-read: jpc=0xFFFF_FFFC → instr_pc 0xFFFF_FFFC then 0x0000_0000. Assert reset during WAIT and return rvalid one cycle after deassert → the response is ignored and the first instr_pc is 0x3000.
